// File: rtl/add32_resp_checker.sv
// add32_resp_checker: response end of the add32 test flow.
// Accepted operand vectors pass through a LAT-deep delay line so that each one
// lines up with the DUT result for that vector. At that point the checker
// computes the golden W+1 bit sum and compares it with dut_cout/dut_sum.
// It counts compares and mismatches, records the index of the first failing
// vector, and reports done/pass once every programmed vector has been checked.
module add32_resp_checker #(
  parameter int W     = 32,
  parameter int LAT   = 0,
  parameter int CNT_W = 12
) (
  input  logic             m_clock,
  input  logic             p_reset,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vec,
  input  logic             vec_valid,
  input  logic [W-1:0]     vec_a,
  input  logic [W-1:0]     vec_b,
  input  logic             vec_cin,
  input  logic [W-1:0]     dut_sum,
  input  logic             dut_cout,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] chk_count,
  output logic [CNT_W-1:0] err_count,
  output logic             first_err_valid,
  output logic [CNT_W-1:0] first_err_idx
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  // Payload carried alongside each accepted vector through the delay line.
  typedef struct packed {
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic             cin;
    logic [CNT_W-1:0] idx;
  } pay_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [CNT_W-1:0] chk_q, chk_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [CNT_W-1:0] fidx_q, fidx_d;
  logic             fev_q, fev_d;
  logic             busy_q, done_q, pass_q;

  logic             accept;
  logic [CNT_W-1:0] acc_inc;
  pay_t             pay_in;
  logic             cmp_vld;
  pay_t             cmp_pay;
  logic [W:0]       exp_res;
  logic             mismatch;

  // Acceptance is gated by the latched count, so vectors past num_vec are
  // dropped even though the stimulus source keeps streaming.
  assign accept  = (state_q == S_RUN) && vec_valid && (acc_q != num_q);
  assign acc_inc = acc_q + CNT_W'(1);

  // Capture the incoming vector and its acceptance index.
  always_comb begin
    pay_in     = '0;
    pay_in.a   = vec_a;
    pay_in.b   = vec_b;
    pay_in.cin = vec_cin;
    pay_in.idx = acc_q;
  end

  if (LAT == 0) begin : g_comb
    // A combinational DUT is compared at the same edge that accepts the vector.
    assign cmp_vld = accept;
    assign cmp_pay = pay_in;
  end else begin : g_pipe
    logic [LAT-1:0] vld_pipe;
    pay_t [LAT-1:0] pay_pipe;

    // Delay line that shifts every cycle, including gaps, so the alignment
    // with the DUT latency does not depend on the stimulus pattern.
    always_ff @(posedge m_clock) begin
      if (p_reset) begin
        vld_pipe <= '0;
        pay_pipe <= '0;
      end else begin
        vld_pipe[0] <= accept;
        pay_pipe[0] <= pay_in;
        for (int i = 1; i < LAT; i++) begin
          vld_pipe[i] <= vld_pipe[i-1];
          pay_pipe[i] <= pay_pipe[i-1];
        end
      end
    end

    assign cmp_vld = vld_pipe[LAT-1];
    assign cmp_pay = pay_pipe[LAT-1];
  end

  // The golden result is computed at W+1 bits, so the carry out falls into the top bit.
  assign exp_res  = {1'b0, cmp_pay.a} + {1'b0, cmp_pay.b} + {{W{1'b0}}, cmp_pay.cin};
  assign mismatch = cmp_vld && ({dut_cout, dut_sum} != exp_res);

  // Next-state logic: result accounting, then the FSM. A start clears the
  // results after the accounting, but compares never fire in IDLE/DONE.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    num_d   = num_q;
    chk_d   = chk_q;
    err_d   = err_q;
    fev_d   = fev_q;
    fidx_d  = fidx_q;

    if (cmp_vld) begin
      chk_d = chk_q + CNT_W'(1);
      if (mismatch) begin
        if (err_q != '1) err_d = err_q + CNT_W'(1);
        if (!fev_q) begin
          fev_d  = 1'b1;
          fidx_d = cmp_pay.idx;
        end
      end
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          acc_d   = '0;
          chk_d   = '0;
          err_d   = '0;
          fev_d   = 1'b0;
          fidx_d  = '0;
          num_d   = num_vec;
          state_d = (num_vec == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (accept) begin
          acc_d = acc_inc;
          if (acc_inc == num_q) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Once every accepted vector has been compared at an earlier edge, the run is finished.
        if (chk_q == num_q) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and result registers; status outputs are registered from the next state.
  always_ff @(posedge m_clock) begin
    if (p_reset) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      num_q   <= '0;
      chk_q   <= '0;
      err_q   <= '0;
      fev_q   <= 1'b0;
      fidx_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      num_q   <= num_d;
      chk_q   <= chk_d;
      err_q   <= err_d;
      fev_q   <= fev_d;
      fidx_q  <= fidx_d;
      busy_q  <= (state_d == S_RUN) || (state_d == S_DRAIN);
      done_q  <= (state_d == S_DONE);
      pass_q  <= (state_d == S_DONE) && (err_d == '0);
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign chk_count       = chk_q;
  assign err_count       = err_q;
  assign first_err_valid = fev_q;
  assign first_err_idx   = fidx_q;

endmodule

// File: tb/tb_add32_resp_checker.sv
// Bench for add32_resp_checker: one instance with LAT=0, fed directly by the
// hand-computed DUT results, and one instance with LAT=2, fed by a model that
// delays those results by a selectable number of cycles. Expected run
// summaries go into per-instance queues, and a monitor pops and checks one
// summary on each rising edge of done.
module tb_add32_resp_checker;
  localparam int W  = 32;
  localparam int CW = 12;

  typedef struct {
    string name;
    int    chk;
    int    err;
    bit    err_gt0;
    bit    fev;
    int    fidx;
    bit    pass;
  } exp_t;

  logic          m_clock = 1'b0;
  logic          p_reset = 1'b1;
  logic          start0 = 1'b0, start2 = 1'b0;
  logic [CW-1:0] num_vec = '0;
  logic          vec_valid = 1'b0;
  logic [W-1:0]  vec_a = '0, vec_b = '0;
  logic          vec_cin = 1'b0;
  logic [W-1:0]  drv_sum = '0;
  logic          drv_cout = 1'b0;

  logic [W:0]    hist [0:3];
  int            dly = 2;
  logic [W-1:0]  dut_sum2;
  logic          dut_cout2;

  logic          busy0, done0, pass0, fev0;
  logic [CW-1:0] chk0, err0, fidx0;
  logic          busy2, done2, pass2, fev2;
  logic [CW-1:0] chk2, err2, fidx2;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t q0[$];
  exp_t q2[$];
  logic d0p = 1'b0, d2p = 1'b0;

  always #5 m_clock = ~m_clock;

  // Latency model for the LAT=2 instance: hist[k] holds the result that was
  // driven k+1 edges ago.
  always @(posedge m_clock) begin
    hist[0] <= {drv_cout, drv_sum};
    for (int i = 1; i < 4; i++) hist[i] <= hist[i-1];
  end
  assign {dut_cout2, dut_sum2} = hist[dly-1];

  add32_resp_checker #(.W(W), .LAT(0), .CNT_W(CW)) u_dut0 (
    .m_clock(m_clock), .p_reset(p_reset), .start(start0), .num_vec(num_vec),
    .vec_valid(vec_valid), .vec_a(vec_a), .vec_b(vec_b), .vec_cin(vec_cin),
    .dut_sum(drv_sum), .dut_cout(drv_cout),
    .busy(busy0), .done(done0), .pass(pass0), .chk_count(chk0), .err_count(err0),
    .first_err_valid(fev0), .first_err_idx(fidx0));

  add32_resp_checker #(.W(W), .LAT(2), .CNT_W(CW)) u_dut2 (
    .m_clock(m_clock), .p_reset(p_reset), .start(start2), .num_vec(num_vec),
    .vec_valid(vec_valid), .vec_a(vec_a), .vec_b(vec_b), .vec_cin(vec_cin),
    .dut_sum(dut_sum2), .dut_cout(dut_cout2),
    .busy(busy2), .done(done2), .pass(pass2), .chk_count(chk2), .err_count(err2),
    .first_err_valid(fev2), .first_err_idx(fidx2));

  task automatic check(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_checks++;
    n_errors++;
    $display("FAIL %s", nm);
  endtask

  task automatic mon_cmp(input exp_t e, input logic [CW-1:0] c, input logic [CW-1:0] er,
                         input logic fv, input logic [CW-1:0] fi, input logic ps);
    check({e.name, " chk_count"}, c, e.chk);
    if (e.err_gt0) check({e.name, " err_count>0"}, (er != 0), 1);
    else begin
      check({e.name, " err_count"}, er, e.err);
      if (e.fev) check({e.name, " first_err_idx"}, fi, e.fidx);
    end
    check({e.name, " first_err_valid"}, fv, e.fev);
    check({e.name, " pass"}, ps, e.pass);
  endtask

  // Monitor: every rising edge of done retires one expected run summary.
  always @(negedge m_clock) begin
    if (done0 && !d0p) begin
      if (q0.size() == 0) fail_now("dut0 done with no expected run");
      else mon_cmp(q0.pop_front(), chk0, err0, fev0, fidx0, pass0);
    end
    if (done2 && !d2p) begin
      if (q2.size() == 0) fail_now("dut2 done with no expected run");
      else mon_cmp(q2.pop_front(), chk2, err2, fev2, fidx2, pass2);
    end
    d0p = done0;
    d2p = done2;
  end

  // Drive one cycle of inputs just after the falling edge.
  task automatic drive(input logic s0, input logic s2, input logic [CW-1:0] n, input logic v,
                       input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                       input logic [W-1:0] s, input logic co);
    @(negedge m_clock);
    start0 = s0; start2 = s2; num_vec = n; vec_valid = v;
    vec_a = a; vec_b = b; vec_cin = c; drv_sum = s; drv_cout = co;
  endtask

  task automatic idle();
    drive(0, 0, '0, 0, '0, '0, 0, '0, 0);
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                      input logic [W-1:0] s, input logic co);
    drive(0, 0, '0, 1, a, b, c, s, co);
  endtask

  task automatic start_run(input int inst, input logic [CW-1:0] n);
    drive(inst == 0, inst == 2, n, 0, '0, '0, 0, '0, 0);
  endtask

  // Count idle cycles after the last vector until done is seen; bounded.
  task automatic wait_done(input int inst, input int exp_k, input string nm);
    int k;
    k = 0;
    for (int i = 1; i <= 30 && k == 0; i++) begin
      idle();
      if ((inst == 0) ? done0 : done2) k = i;
    end
    if (k == 0) fail_now({nm, " timeout waiting for done"});
    else check({nm, " done latency"}, k, exp_k);
  endtask

  task automatic push(input int inst, input string nm, input int c, input int e, input bit gt0,
                      input bit fv, input int fi, input bit ps);
    exp_t x;
    x.name = nm; x.chk = c; x.err = e; x.err_gt0 = gt0; x.fev = fv; x.fidx = fi; x.pass = ps;
    if (inst == 0) q0.push_back(x);
    else q2.push_back(x);
  endtask

  task automatic std_vecs(input bit bad1, input bit bad2);
    send(32'h00000001, 32'h00000002, 0, 32'h00000003, 0);
    send(32'hFFFFFFFF, 32'h00000001, 0, bad1 ? 32'h00000001 : 32'h00000000, 1);
    send(32'hFFFFFFFF, 32'hFFFFFFFF, 1, bad2 ? 32'h00000001 : 32'hFFFFFFFF, 1);
  endtask

  task automatic lat2_vecs();
    send(32'h00000001, 32'h00000001, 0, 32'h00000002, 0);
    send(32'h00000002, 32'h00000002, 0, 32'h00000004, 0);
    idle();
    send(32'h00000003, 32'h00000003, 0, 32'h00000006, 0);
    send(32'h00000004, 32'h00000004, 1, 32'h00000009, 0);
    send(32'h80000000, 32'h80000000, 1, 32'h00000001, 1);
  endtask

  initial begin
    // Reset state
    idle(); idle();
    check("reset busy0/done0/pass0", {busy0, done0, pass0}, 0);
    check("reset counters0", {chk0, err0, fidx0, fev0}, 0);
    check("reset dut2 outputs", {busy2, done2, pass2, chk2, err2, fidx2, fev2}, 0);
    p_reset = 1'b0;

    // num_vec == 0: done/pass on the next cycle, never busy
    push(0, "nv0", 0, 0, 0, 0, 0, 1);
    start_run(0, 0);
    check("nv0 busy at start", busy0, 0);
    idle();
    check("nv0 done", done0, 1);
    check("nv0 pass", pass0, 1);
    check("nv0 busy", busy0, 0);

    // LAT=0, three correct vectors
    push(0, "t1", 3, 0, 0, 0, 0, 1);
    start_run(0, 3);
    std_vecs(0, 0);
    wait_done(0, 2, "t1");

    // one corrupted result at idx 1
    push(0, "t2a", 3, 1, 0, 1, 1, 0);
    start_run(0, 3);
    std_vecs(1, 0);
    wait_done(0, 2, "t2a");

    // errors at idx 1 and 2: first index stays 1
    push(0, "t2b", 3, 2, 0, 1, 1, 0);
    start_run(0, 3);
    std_vecs(1, 1);
    wait_done(0, 2, "t2b");

    // LAT=2 with a matching 2-cycle DUT, gap after the 2nd vector
    dly = 2;
    push(2, "t3a", 5, 0, 0, 0, 0, 1);
    start_run(2, 5);
    lat2_vecs();
    wait_done(2, 4, "t3a");

    // same stream, DUT now one cycle too slow
    dly = 3;
    push(2, "t3b", 5, 0, 1, 1, 0, 0);
    start_run(2, 5);
    lat2_vecs();
    wait_done(2, 4, "t3b");
    dly = 2;

    // num_vec=4 with 6 pulses; a start (num_vec=7) in RUN is ignored
    push(0, "t5", 4, 0, 0, 0, 0, 1);
    start_run(0, 4);
    send(32'h00000010, 32'h00000020, 0, 32'h00000030, 0);
    drive(1, 0, 12'd7, 1, 32'h7FFFFFFF, 32'h00000001, 0, 32'h80000000, 0);
    send(32'h00000000, 32'h00000000, 1, 32'h00000001, 0);
    send(32'hFFFFFFFF, 32'h00000000, 1, 32'h00000000, 1);
    send(32'h00000001, 32'h00000001, 0, 32'h0000DEAD, 0);
    check("t5 done before extra pulse", done0, 0);
    send(32'h00000002, 32'h00000002, 0, 32'h0000BEEF, 0);
    check("t5 done", done0, 1);
    check("t5 chk_count", chk0, 4);

    // restart from DONE clears the counters
    push(0, "t5r", 2, 0, 0, 0, 0, 1);
    start_run(0, 2);
    send(32'h00000005, 32'h00000006, 1, 32'h0000000C, 0);
    check("t5r cleared chk", chk0, 0);
    check("t5r busy", busy0, 1);
    check("t5r done low", done0, 0);
    send(32'h12345678, 32'h11111111, 0, 32'h23456789, 0);
    wait_done(0, 2, "t5r");

    // reset mid-run after 2 of 4 vectors
    start_run(0, 4);
    send(32'h00000001, 32'h00000001, 0, 32'h00000002, 0);
    send(32'h00000002, 32'h00000002, 0, 32'h00000004, 0);
    idle();
    p_reset = 1'b1;
    idle();
    p_reset = 1'b0;
    check("t6 dut0 outputs after reset", {busy0, done0, pass0, chk0, err0, fidx0, fev0}, 0);
    check("t6 dut2 outputs after reset", {busy2, done2, pass2, chk2, err2, fidx2, fev2}, 0);
    send(32'h00000003, 32'h00000003, 0, 32'h00000006, 0);
    send(32'h00000004, 32'h00000004, 0, 32'h00000008, 0);
    idle(); idle();
    check("t6 ignored vectors chk", chk0, 0);
    check("t6 still idle", {busy0, done0}, 0);

    idle(); idle();
    check("dut0 expected runs retired", q0.size(), 0);
    check("dut2 expected runs retired", q2.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
